// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its datapath.
package multi_cycle_controller_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned F7_W      = 7;
    localparam int unsigned IMM_SRC_W = 3;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned ALU_FN_W  = 3;
    localparam int unsigned RES_W     = 2;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_FN_W-1:0] ALU_ADD  = 3'd0;
    localparam logic [ALU_FN_W-1:0] ALU_SUB  = 3'd1;
    localparam logic [ALU_FN_W-1:0] ALU_AND  = 3'd2;
    localparam logic [ALU_FN_W-1:0] ALU_OR   = 3'd3;
    localparam logic [ALU_FN_W-1:0] ALU_XOR  = 3'd4;
    localparam logic [ALU_FN_W-1:0] ALU_SLT  = 3'd5;
    localparam logic [ALU_FN_W-1:0] ALU_SLTU = 3'd6;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'd4;

    localparam logic [SRC_W-1:0] SRC_A_PC     = 2'd0;
    localparam logic [SRC_W-1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [SRC_W-1:0] SRC_A_REG    = 2'd2;

    localparam logic [SRC_W-1:0] SRC_B_REG    = 2'd0;
    localparam logic [SRC_W-1:0] SRC_B_IMM    = 2'd1;
    localparam logic [SRC_W-1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [RES_W-1:0] RES_ALU_OUT  = 2'd0;
    localparam logic [RES_W-1:0] RES_MDR      = 2'd1;
    localparam logic [RES_W-1:0] RES_ALU      = 2'd2;
    localparam logic [RES_W-1:0] RES_IMM      = 2'd3;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_BRANCH, S_JAL_CALC, S_JALR_CALC, S_JUMP, S_LINK, S_LUI, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_BR
    } op_class_t;

    // Which ALU-function decode table applies to an opcode.
    function automatic op_class_t op_class(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_BRANCH: return CLS_BR;
            default:   return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_control.sv
// ALU function decode for R-type, I-type and branch instructions.
module multi_cycle_controller_alu_control
    import multi_cycle_controller_pkg::*;
(
    input  logic [1:0] i_op_class,
    input  logic [2:0] i_f3,
    input  logic [6:0] i_f7,
    output logic [2:0] o_alu_fn,
    output logic       o_illegal
);

    // f3 table shared by R (f7 base) and I forms; shifts are unsupported.
    function automatic logic [3:0] base_fn(input logic [F3_W-1:0] f3);
        case (f3)
            3'b000:  return {1'b0, ALU_ADD};
            3'b111:  return {1'b0, ALU_AND};
            3'b110:  return {1'b0, ALU_OR};
            3'b100:  return {1'b0, ALU_XOR};
            3'b010:  return {1'b0, ALU_SLT};
            3'b011:  return {1'b0, ALU_SLTU};
            default: return {1'b1, ALU_ADD};
        endcase
    endfunction

    logic [3:0] w_base;

    assign w_base = base_fn(i_f3);

    // Select function and legality per instruction class.
    always_comb begin
        o_alu_fn  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_op_class)
            CLS_R: begin
                if (i_f7 == F7_ALT) begin
                    o_alu_fn  = ALU_SUB;
                    o_illegal = (i_f3 != 3'b000);
                end else if (i_f7 == F7_BASE) begin
                    o_alu_fn  = w_base[2:0];
                    o_illegal = w_base[3];
                end else begin
                    o_illegal = 1'b1;
                end
            end
            CLS_I: begin
                o_alu_fn  = w_base[2:0];
                o_illegal = w_base[3];
            end
            CLS_BR: begin
                case (i_f3[2:1])
                    2'b00:   o_alu_fn = ALU_SUB;
                    2'b10:   o_alu_fn = ALU_SLT;
                    2'b11:   o_alu_fn = ALU_SLTU;
                    default: o_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Control FSM of the multi-cycle RV32I core: one instruction per FETCH..FETCH pass.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       old_pc_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_function,
    output logic [1:0] result_src,
    output logic       halted
);

    state_t    r_state;
    state_t    w_next_state;
    op_class_t w_op_class;
    logic [2:0] w_alu_fn;
    logic      w_fn_illegal;
    logic      w_branch_invert;

    assign w_op_class = op_class(opcode);
    // beq/bge/bgeu take on zero=1; bne/blt/bltu take on zero=0.
    assign w_branch_invert = f3[0] ^ f3[2];

    multi_cycle_controller_alu_control u_alu_control (
        .i_op_class (w_op_class),
        .i_f3       (f3),
        .i_f7       (f7),
        .o_alu_fn   (w_alu_fn),
        .o_illegal  (w_fn_illegal)
    );

    // State register; reset restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control outputs; write enables are suppressed while in reset.
    always_comb begin
        w_next_state = r_state;
        adr_src      = ADR_PC;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        old_pc_write = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        imm_src      = IMM_I;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_REG;
        alu_function = ALU_ADD;
        result_src   = RES_ALU_OUT;
        halted       = 1'b0;

        case (r_state)
            S_FETCH: begin
                adr_src      = ADR_PC;
                ir_write     = 1'b1;
                old_pc_write = 1'b1;
                alu_src_a    = SRC_A_PC;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALU;
                pc_write     = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_B;
                case (opcode)
                    OP_R:      w_next_state = w_fn_illegal ? S_HALT : S_EXEC_R;
                    OP_I:      w_next_state = w_fn_illegal ? S_HALT : S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  w_next_state = S_MEM_ADR;
                    OP_BRANCH: w_next_state = w_fn_illegal ? S_HALT : S_BRANCH;
                    OP_JAL:    w_next_state = S_JAL_CALC;
                    OP_JALR:   w_next_state = S_JALR_CALC;
                    OP_LUI:    w_next_state = S_LUI;
                    default:   w_next_state = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_REG;
                alu_function = w_alu_fn;
                w_next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_I;
                alu_function = w_alu_fn;
                w_next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src   = RES_ALU_OUT;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_IMM;
                imm_src      = (opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src      = ADR_RESULT;
                result_src   = RES_ALU_OUT;
                w_next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src   = RES_MDR;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src      = ADR_RESULT;
                result_src   = RES_ALU_OUT;
                mem_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_REG;
                result_src   = RES_ALU_OUT;
                alu_function = w_alu_fn;
                pc_write     = zero ^ w_branch_invert;
                w_next_state = S_FETCH;
            end
            S_JAL_CALC: begin
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_J;
                w_next_state = S_JUMP;
            end
            S_JALR_CALC: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_I;
                w_next_state = S_JUMP;
            end
            S_JUMP: begin
                // Target leaves alu_out into pc while old_pc+4 is computed for the link.
                result_src   = RES_ALU_OUT;
                pc_write     = 1'b1;
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_FOUR;
                w_next_state = S_LINK;
            end
            S_LINK: begin
                result_src   = RES_ALU_OUT;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_LUI: begin
                imm_src      = IMM_U;
                result_src   = RES_IMM;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                halted       = 1'b1;
                w_next_state = S_HALT;
            end
            default: w_next_state = S_FETCH;
        endcase

        if (reset) begin
            mem_write    = 1'b0;
            ir_write     = 1'b0;
            old_pc_write = 1'b0;
            pc_write     = 1'b0;
            reg_write    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: per-instruction step model plus directed pins.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       adr_src, mem_write, ir_write, old_pc_write, pc_write, reg_write, halted;
    logic [2:0] imm_src, alu_function;
    logic [1:0] alu_src_a, alu_src_b, result_src;

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .f3           (f3),
        .f7           (f7),
        .zero         (zero),
        .adr_src      (adr_src),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .old_pc_write (old_pc_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .imm_src      (imm_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_function (alu_function),
        .result_src   (result_src),
        .halted       (halted)
    );

    typedef struct packed {
        logic       adr;
        logic       mw;
        logic       irw;
        logic       opw;
        logic       pcw;
        logic       rw;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] fn;
        logic [1:0] rs;
        logic       hlt;
    } vec_t;

    vec_t dut_v;
    assign dut_v = {adr_src, mem_write, ir_write, old_pc_write, pc_write, reg_write,
                    imm_src, alu_src_a, alu_src_b, alu_function, result_src, halted};

    int   vectors    = 0;
    int   miscompares = 0;
    logic chk_full   = 1'b0;
    logic chk_rst    = 1'b0;
    vec_t exp_v;
    int   cur_step   = 0;
    vec_t rec [16];

    // {legal, fn} for R (is_r=1) and I forms.
    function automatic logic [3:0] ri_fn(input logic is_r, input logic [2:0] ff3, input logic [6:0] ff7);
        if (is_r && ff7 == 7'h20) return (ff3 == 3'd0) ? 4'b1001 : 4'b0000;
        if (is_r && ff7 != 7'h00) return 4'b0000;
        case (ff3)
            3'd0: return 4'b1000;
            3'd7: return 4'b1010;
            3'd6: return 4'b1011;
            3'd4: return 4'b1100;
            3'd2: return 4'b1101;
            3'd3: return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    // Cycles an instruction takes; 0 means it ends in HALT.
    function automatic int cycles_of(input logic [6:0] op, input logic [2:0] ff3, input logic [6:0] ff7);
        case (op)
            7'h33:        return ri_fn(1'b1, ff3, ff7) >= 4'd8 ? 4 : 0;
            7'h13:        return ri_fn(1'b0, ff3, ff7) >= 4'd8 ? 4 : 0;
            7'h03:        return 5;
            7'h23:        return 4;
            7'h63:        return (ff3 == 3'd2 || ff3 == 3'd3) ? 0 : 3;
            7'h6F, 7'h67: return 5;
            7'h37:        return 3;
            default:      return 0;
        endcase
    endfunction

    // Expected controls at step k of an instruction, given the zero flag that cycle.
    function automatic vec_t model(input logic [6:0] op, input logic [2:0] ff3,
                                   input logic [6:0] ff7, input int k, input logic z);
        vec_t v;
        logic [3:0] ri;
        v = '0;
        if (k == 0) begin
            v.irw = 1'b1; v.opw = 1'b1; v.pcw = 1'b1; v.b = 2'd2; v.rs = 2'd2;
            return v;
        end
        if (k == 1) begin
            v.a = 2'd1; v.b = 2'd1; v.imm = 3'd2;
            return v;
        end
        if (cycles_of(op, ff3, ff7) == 0) begin
            v.hlt = 1'b1;
            return v;
        end
        case (op)
            7'h33, 7'h13: begin
                ri = ri_fn(op == 7'h33, ff3, ff7);
                if (k == 2) begin
                    v.a = 2'd2; v.b = (op == 7'h33) ? 2'd0 : 2'd1; v.fn = ri[2:0];
                end else begin
                    v.rw = 1'b1;
                end
            end
            7'h03: begin
                if (k == 2) begin v.a = 2'd2; v.b = 2'd1; end
                else if (k == 3) v.adr = 1'b1;
                else begin v.rs = 2'd1; v.rw = 1'b1; end
            end
            7'h23: begin
                if (k == 2) begin v.a = 2'd2; v.b = 2'd1; v.imm = 3'd1; end
                else begin v.adr = 1'b1; v.mw = 1'b1; end
            end
            7'h63: begin
                v.a  = 2'd2;
                v.fn = (ff3[2] == 1'b0) ? 3'd1 : (ff3[1] ? 3'd6 : 3'd5);
                v.pcw = (ff3 == 3'd0 || ff3 == 3'd5 || ff3 == 3'd7) ? z : ~z;
            end
            7'h6F, 7'h67: begin
                if (k == 2) begin
                    v.a = (op == 7'h6F) ? 2'd1 : 2'd2; v.b = 2'd1;
                    v.imm = (op == 7'h6F) ? 3'd4 : 3'd0;
                end else if (k == 3) begin
                    v.pcw = 1'b1; v.a = 2'd1; v.b = 2'd2;
                end else begin
                    v.rw = 1'b1;
                end
            end
            7'h37: begin
                v.imm = 3'd3; v.rs = 2'd3; v.rw = 1'b1;
            end
            default: v.hlt = 1'b1;
        endcase
        return v;
    endfunction

    // Compare process: full vector in normal cycles, write enables only in reset.
    always @(negedge clk) begin
        if (chk_rst) begin
            vectors++;
            if ({mem_write, ir_write, old_pc_write, pc_write, reg_write} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_enables got=%b want=00000",
                         {mem_write, ir_write, old_pc_write, pc_write, reg_write});
            end
        end else if (chk_full) begin
            vectors++;
            rec[cur_step[3:0]] = dut_v;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL step%0d op=%h f3=%0d f7=%h zero=%b got=%b want=%b",
                         cur_step, opcode, f3, f7, zero, dut_v, exp_v);
            end
        end
    end

    task automatic pin(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic do_reset(input int n);
        chk_full = 1'b0;
        chk_rst  = 1'b1;
        reset    = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        chk_rst = 1'b0;
    endtask

    // limit < natural length aborts with reset; for halting instructions it is the halt length.
    task automatic run_instr(input logic [31:0] w, input int limit, input int zmode);
        int steps;
        opcode = w[6:0];
        f3     = w[14:12];
        f7     = w[31:25];
        steps  = cycles_of(opcode, f3, f7);
        if (steps == 0) steps = limit;
        else if (limit < steps) steps = limit;
        for (int k = 0; k < steps; k++) begin
            zero     = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            cur_step = k;
            exp_v    = model(opcode, f3, f7, k, zero);
            chk_full = 1'b1;
            @(posedge clk);
            #1;
        end
        if (steps < 16 && (cycles_of(opcode, f3, f7) == 0 || steps < cycles_of(opcode, f3, f7)))
            do_reset(1 + int'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [6:0]  rop;
        logic [2:0]  rf3;
        logic [6:0]  rf7;
        logic [31:0] rw;
        int          sel;
        int          lim;
        reset  = 1'b1;
        opcode = 7'h0;
        f3     = 3'h0;
        f7     = 7'h0;
        zero   = 1'b0;
        do_reset(2);

        run_instr(32'h002081B3, 99, -1);
        pin("first_fetch_irw_pcw_opw", {5'd0, rec[0].irw, rec[0].pcw, rec[0].opw}, 8'h07);
        pin("add_exec_fn", 8'(rec[2].fn), 8'h00);
        pin("add_exec_a", 8'(rec[2].a), 8'h02);
        pin("add_wb_reg_write", 8'(rec[3].rw), 8'h01);
        run_instr(32'h402081B3, 99, -1);
        pin("sub_exec_fn", 8'(rec[2].fn), 8'h01);
        run_instr(32'h0080A283, 99, -1);
        pin("lw_read_adr_src", 8'(rec[3].adr), 8'h01);
        pin("lw_wb_result_src", 8'(rec[4].rs), 8'h01);
        run_instr(32'h0050A423, 99, -1);
        pin("sw_mem_write", 8'(rec[3].mw), 8'h01);
        pin("sw_imm_src", 8'(rec[2].imm), 8'h01);
        run_instr(32'h00208463, 99, 1);
        pin("beq_zero1_pc_write", 8'(rec[2].pcw), 8'h01);
        run_instr(32'h00208463, 99, 0);
        pin("beq_zero0_pc_write", 8'(rec[2].pcw), 8'h00);
        run_instr(32'h0020C463, 99, 0);
        pin("blt_zero0_pc_write", 8'(rec[2].pcw), 8'h01);
        pin("blt_fn", 8'(rec[2].fn), 8'h05);
        run_instr(32'h000080E7, 99, -1);
        pin("jalr_jump_pc_write", 8'(rec[3].pcw), 8'h01);
        pin("jalr_link_reg_write", 8'(rec[4].rw), 8'h01);
        run_instr(32'h008000EF, 99, -1);
        pin("jal_imm_src", 8'(rec[2].imm), 8'h04);
        run_instr(32'h0000007F, 12, -1);
        pin("halt_halted", 8'(rec[11].hlt), 8'h01);
        pin("halt_enables", {3'd0, rec[11].mw, rec[11].irw, rec[11].opw, rec[11].pcw, rec[11].rw}, 8'h00);
        run_instr(32'h00000037, 99, -1);
        pin("lui_after_halt_result_src", 8'(rec[2].rs), 8'h03);

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            rf3 = 3'($urandom_range(0, 7));
            rf7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
            case (sel)
                0, 1: rop = 7'h33;
                2:    rop = 7'h13;
                3:    begin rop = 7'h03; rf3 = 3'd2; end
                4:    begin rop = 7'h23; rf3 = 3'd2; end
                5, 6: rop = 7'h63;
                7:    rop = ($urandom_range(0, 1) == 1) ? 7'h6F : 7'h67;
                8:    rop = 7'h37;
                default: rop = 7'($urandom);
            endcase
            rw  = {rf7, 10'($urandom), rf3, 5'($urandom), rop};
            lim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 99;
            if (cycles_of(rop, rf3, rf7) == 0) lim = int'($urandom_range(3, 6));
            run_instr(rw, lim, -1);
        end

        chk_full = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
